// File: rtl/mcsb_cpld.sv
// mcsb_cpld: Micro Channel bus interface for a Sound Blaster compatible card.
//   POS registers + adapter ID, I/O decode and chip selects (YM3812, 2x SAA1099,
//   joystick, DSP), CHRDY wait states for the SAA1099, data buffer control,
//   IRQ routing and MCA DMA arbitration on behalf of the DSP.
// Ports:
//   clk14, chreset_l            clock, synchronous active-low reset
//   cd_setup_l, adl_l, cmd      MCA setup select, address latch, command (all low active)
//   m_io, s0_w_l, s1_r_l, a     cycle type, status, address (latched by adl_l)
//   d                           local data bus (driven on POS reads only)
//   cd_sfdbk, cd_chrdy_l        card selected feedback, channel ready (high = wait)
//   ior_l, iow_l, latched_a0    local strobes and register select
//   *_cs_l                      chip selects, active low
//   cms_dtack_l                 SAA1099 acknowledge
//   irq_in, irq_2/3/5/7         DSP interrupt in, routed interrupt outs
//   bufen_l, bufdir             data transceiver enable / direction (1 = card to MCA)
//   dreq, dack_l, tc_l          DSP DMA handshake
//   arb, arb_grant_l            arbitration bus (open drain) and grant phase
//   preempt_l, burst_l          open drain bus signals
module mcsb_cpld #(
   parameter logic [15:0] ADAPTER_ID = 16'h5103
) (
   input  logic        clk14,
   input  logic        chreset_l,
   input  logic        cd_setup_l,
   input  logic        adl_l,
   input  logic        cmd,
   input  logic        m_io,
   input  logic        s0_w_l,
   input  logic        s1_r_l,
   input  logic [15:0] a,
   inout  wire  [7:0]  d,
   output logic        cd_sfdbk,
   output logic        cd_chrdy_l,
   output logic        ior_l,
   output logic        iow_l,
   output logic        latched_a0,
   output logic        ym_cs_l,
   output logic        joy_cs_l,
   output logic        cms1_6_cs_l,
   output logic        cms7_12_cs_l,
   output logic        dsp_rst_cs_l,
   output logic        dav_cs_l,
   output logic        dsp_wr_cs_l,
   output logic        dsp_rd_cs_l,
   input  logic        cms_dtack_l,
   input  logic        irq_in,
   output logic        irq_2,
   output logic        irq_3,
   output logic        irq_5,
   output logic        irq_7,
   output logic        bufen_l,
   output logic        bufdir,
   input  logic        dreq,
   output logic        dack_l,
   input  logic        tc_l,
   inout  wire  [3:0]  arb,
   input  logic        arb_grant_l,
   inout  wire         preempt_l,
   inout  wire         burst_l
);

   typedef enum logic [1:0] {IDLE, REQ, ARB, GRANT} dma_st_e;

   // ---------------- address / status latch (open while adl_l low) ----------
   logic [15:0] lat_a;
   logic        lat_mio, lat_s0_l, lat_s1_l;

   always_latch begin
      if (!adl_l) begin
         lat_a    <= a;
         lat_mio  <= m_io;
         lat_s0_l <= s0_w_l;
         lat_s1_l <= s1_r_l;
      end
   end

   // ---------------- registers ----------------------------------------------
   logic [7:0] pos2_q, pos2_d, pos3_q, pos3_d;
   logic       gnt_s1_q, gnt_s1_d, gnt_s2_q, gnt_s2_d, gnt_s3_q, gnt_s3_d;
   logic       dreq_s1_q, dreq_s1_d, dreq_s2_q, dreq_s2_d;
   logic [3:0] arb_q, arb_d;
   dma_st_e    state_q, state_d;

   logic       rd, wr, cmd_act, card_en, io_ok, in_win, pos_acc, hit, dack_act;
   logic [4:0] off;
   logic [3:0] arb_lvl, arb_drv;
   logic [7:0] pos_rdata;
   logic       lose, gnt_fall, gnt_rise;
   logic       ym_sel, joy_sel, cms16_sel, cms712_sel, rst_sel, dav_sel, dwr_sel, drd_sel;

   assign rd      = !lat_s1_l;
   assign wr      = !lat_s0_l;
   assign cmd_act = !cmd;
   assign card_en = pos2_q[0];
   assign arb_lvl = pos3_q[7:4];
   // Reset is also applied combinationally so the bus is quiet for the whole
   // reset interval, not just from the first clock edge.
   assign io_ok   = chreset_l && card_en && !lat_mio && cd_setup_l;
   // 32-byte window at 0x200 + 0x20*sel: upper 11 address bits = 16 + sel
   assign in_win  = (lat_a[15:5] == (11'd16 + {8'd0, pos3_q[3:1]}));
   assign off     = lat_a[4:0];
   assign pos_acc = chreset_l && !cd_setup_l && cmd_act;
   assign dack_act = chreset_l && (state_q == GRANT);

   // ---------------- I/O decode ---------------------------------------------
   always_comb begin
      ym_sel = 1'b0; joy_sel = 1'b0; cms16_sel = 1'b0; cms712_sel = 1'b0;
      rst_sel = 1'b0; dav_sel = 1'b0; dwr_sel = 1'b0; drd_sel = 1'b0;
      if (io_ok) begin
         if (in_win) begin
            cms16_sel  = (off[4:1] == 4'h0);
            cms712_sel = (off[4:1] == 4'h1);
            rst_sel    = (off == 5'h06);
            ym_sel     = (off[4:1] == 4'h4);
            drd_sel    = (off == 5'h0A) && rd;
            dwr_sel    = (off == 5'h0C);
            dav_sel    = (off == 5'h0E) && rd;
         end
         if (lat_a[15:1] == 15'h01C4) ym_sel = 1'b1;   // 0x388/0x389 (AdLib)
         if (lat_a[15:3] == 13'h0040) joy_sel = 1'b1;  // 0x200-0x207
      end
   end

   assign hit = ym_sel | joy_sel | cms16_sel | cms712_sel | rst_sel | dav_sel | dwr_sel | drd_sel;

   assign ym_cs_l      = !ym_sel;
   assign joy_cs_l     = !joy_sel;
   assign cms1_6_cs_l  = !cms16_sel;
   assign cms7_12_cs_l = !cms712_sel;
   assign dsp_rst_cs_l = !rst_sel;
   assign dav_cs_l     = !dav_sel;
   assign dsp_wr_cs_l  = !dwr_sel;
   assign dsp_rd_cs_l  = !drd_sel;

   assign ior_l      = !(chreset_l && cmd_act && (hit || dack_act) && rd);
   assign iow_l      = !(chreset_l && cmd_act && (hit || dack_act) && wr);
   assign bufen_l    = !(chreset_l && cmd_act && (hit || pos_acc || dack_act));
   assign bufdir     = chreset_l && rd;
   assign cd_sfdbk   = hit || pos_acc;
   assign latched_a0 = lat_a[0];
   // Hold the channel not-ready until the SAA1099 acknowledges the write.
   assign cd_chrdy_l = (cms16_sel || cms712_sel) && wr && cms_dtack_l;

   // ---------------- POS read data ------------------------------------------
   always_comb begin
      pos_rdata = 8'h00;
      case (lat_a[2:0])
         3'd0:    pos_rdata = ADAPTER_ID[7:0];
         3'd1:    pos_rdata = ADAPTER_ID[15:8];
         3'd2:    pos_rdata = pos2_q;
         3'd3:    pos_rdata = pos3_q;
         default: pos_rdata = 8'h00;
      endcase
   end

   assign d = (pos_acc && rd) ? pos_rdata : 8'hzz;

   // ---------------- IRQ routing --------------------------------------------
   logic irq_act;
   assign irq_act = chreset_l && card_en && irq_in;
   assign irq_2 = irq_act && (pos2_q[2:1] == 2'd0);
   assign irq_3 = irq_act && (pos2_q[2:1] == 2'd1);
   assign irq_5 = irq_act && (pos2_q[2:1] == 2'd2);
   assign irq_7 = irq_act && (pos2_q[2:1] == 2'd3);

   // ---------------- DMA arbitration ----------------------------------------
   assign gnt_fall = gnt_s3_q && !gnt_s2_q;
   assign gnt_rise = !gnt_s3_q && gnt_s2_q;

   // Drive zeros of the level MSB first; once a higher bit where we hold 1 is
   // seen pulled low by another master we have lost, so release lower bits.
   // The sampled bus (arb_q) is used to keep the open-drain loop out of logic.
   always_comb begin
      arb_drv = 4'b0000;
      lose    = 1'b0;
      if (chreset_l && state_q == ARB) begin
         for (int i = 3; i >= 0; i--) begin
            if (!arb_lvl[i] && !lose) arb_drv[i] = 1'b1;
            if (arb_lvl[i] && !arb_q[i]) lose = 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_arb
      assign arb[gi] = arb_drv[gi] ? 1'b0 : 1'bz;
   end

   assign preempt_l = (chreset_l && (state_q == REQ || state_q == ARB)) ? 1'b0 : 1'bz;
   assign burst_l   = 1'bz;
   assign dack_l    = !dack_act;

   always_comb begin
      pos2_d    = pos2_q;
      pos3_d    = pos3_q;
      gnt_s1_d  = arb_grant_l;
      gnt_s2_d  = gnt_s1_q;
      gnt_s3_d  = gnt_s2_q;
      dreq_s1_d = dreq;
      dreq_s2_d = dreq_s1_q;
      arb_d     = arb;
      state_d   = state_q;
      if (pos_acc && wr && lat_a[2:0] == 3'd2) pos2_d = d;
      if (pos_acc && wr && lat_a[2:0] == 3'd3) pos3_d = d;
      case (state_q)
         IDLE:  if (dreq_s2_q && card_en) state_d = REQ;
         REQ: begin
            if (!dreq_s2_q || !card_en) state_d = IDLE;
            else if (gnt_s2_q)          state_d = ARB;
         end
         ARB:   if (gnt_fall) state_d = (arb_q == arb_lvl) ? GRANT : REQ;
         GRANT: if (gnt_rise || !tc_l) state_d = (dreq_s2_q && card_en) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk14) begin
      if (!chreset_l) begin
         pos2_q    <= 8'h00;
         pos3_q    <= 8'h00;
         gnt_s1_q  <= 1'b1;
         gnt_s2_q  <= 1'b1;
         gnt_s3_q  <= 1'b1;
         dreq_s1_q <= 1'b0;
         dreq_s2_q <= 1'b0;
         arb_q     <= 4'hF;
         state_q   <= IDLE;
      end else begin
         pos2_q    <= pos2_d;
         pos3_q    <= pos3_d;
         gnt_s1_q  <= gnt_s1_d;
         gnt_s2_q  <= gnt_s2_d;
         gnt_s3_q  <= gnt_s3_d;
         dreq_s1_q <= dreq_s1_d;
         dreq_s2_q <= dreq_s2_d;
         arb_q     <= arb_d;
         state_q   <= state_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{pos2_q[7:3], pos3_q[0], burst_l};

endmodule

// File: tb/tb_mcsb_cpld.sv
`timescale 1ns/1ps
module tb_mcsb_cpld;

   logic        clk14 = 1'b0;
   logic        chreset_l, cd_setup_l, adl_l, cmd, m_io, s0_w_l, s1_r_l;
   logic [15:0] a;
   logic        cms_dtack_l, irq_in, dreq, tc_l, arb_grant_l;
   wire  [7:0]  d;
   wire  [3:0]  arb;
   wire         preempt_l, burst_l;
   logic        cd_sfdbk, cd_chrdy_l, ior_l, iow_l, latched_a0;
   logic        ym_cs_l, joy_cs_l, cms1_6_cs_l, cms7_12_cs_l, dsp_rst_cs_l, dav_cs_l, dsp_wr_cs_l, dsp_rd_cs_l;
   logic        irq_2, irq_3, irq_5, irq_7, bufen_l, bufdir, dack_l;

   logic [7:0]  tb_d;
   logic        tb_d_en, arb_force;

   assign d   = tb_d_en ? tb_d : 8'hzz;
   assign arb = arb_force ? 4'b0000 : 4'bzzzz;
   for (genvar gi = 0; gi < 8; gi++) begin : g_pu_d
      pullup (d[gi]);
   end
   for (genvar gi = 0; gi < 4; gi++) begin : g_pu_arb
      pullup (arb[gi]);
   end
   pullup (preempt_l);
   pullup (burst_l);

   always #35 clk14 = ~clk14;

   mcsb_cpld dut (
      .clk14(clk14), .chreset_l(chreset_l), .cd_setup_l(cd_setup_l), .adl_l(adl_l),
      .cmd(cmd), .m_io(m_io), .s0_w_l(s0_w_l), .s1_r_l(s1_r_l), .a(a), .d(d),
      .cd_sfdbk(cd_sfdbk), .cd_chrdy_l(cd_chrdy_l), .ior_l(ior_l), .iow_l(iow_l),
      .latched_a0(latched_a0), .ym_cs_l(ym_cs_l), .joy_cs_l(joy_cs_l),
      .cms1_6_cs_l(cms1_6_cs_l), .cms7_12_cs_l(cms7_12_cs_l), .dsp_rst_cs_l(dsp_rst_cs_l),
      .dav_cs_l(dav_cs_l), .dsp_wr_cs_l(dsp_wr_cs_l), .dsp_rd_cs_l(dsp_rd_cs_l),
      .cms_dtack_l(cms_dtack_l), .irq_in(irq_in), .irq_2(irq_2), .irq_3(irq_3),
      .irq_5(irq_5), .irq_7(irq_7), .bufen_l(bufen_l), .bufdir(bufdir), .dreq(dreq),
      .dack_l(dack_l), .tc_l(tc_l), .arb(arb), .arb_grant_l(arb_grant_l),
      .preempt_l(preempt_l), .burst_l(burst_l)
   );

   // observation fields
   localparam int F_D = 0, F_CS = 1, F_STB = 2, F_SFB = 3, F_CHRDY = 4, F_A0 = 5,
                  F_IRQ = 6, F_DACK = 7, F_PRE = 8, F_ARB = 9, F_BURST = 10;

   typedef struct {
      int         fld;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // CS order: {ym, joy, cms1_6, cms7_12, dsp_rst, dav, dsp_wr, dsp_rd}
   // STB order: {ior_l, iow_l, bufen_l, bufdir}; IRQ order: {irq_2, irq_3, irq_5, irq_7}
   function automatic logic [7:0] actual(input int f);
      case (f)
         F_D:     return d;
         F_CS:    return {ym_cs_l, joy_cs_l, cms1_6_cs_l, cms7_12_cs_l,
                          dsp_rst_cs_l, dav_cs_l, dsp_wr_cs_l, dsp_rd_cs_l};
         F_STB:   return {4'b0, ior_l, iow_l, bufen_l, bufdir};
         F_SFB:   return {7'b0, cd_sfdbk};
         F_CHRDY: return {7'b0, cd_chrdy_l};
         F_A0:    return {7'b0, latched_a0};
         F_IRQ:   return {4'b0, irq_2, irq_3, irq_5, irq_7};
         F_DACK:  return {7'b0, dack_l};
         F_PRE:   return {7'b0, preempt_l};
         F_ARB:   return {4'b0, arb};
         F_BURST: return {7'b0, burst_l};
         default: return 8'hxx;
      endcase
   endfunction

   // monitor: compares every queued expectation at the falling edge
   always @(negedge clk14) begin : mon
      exp_t       e;
      logic [7:0] act;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         act = actual(e.fld);
         n_chk++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", e.name, act, e.val, $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk14);
      #1;
   endtask

   task automatic exp(input int f, input logic [7:0] v, input string nm);
      exp_t e;
      e.fld = f; e.val = v; e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic start_cycle(input logic setup, input logic mem, input logic wrc,
                              input logic [15:0] addr, input logic [7:0] wd);
      tick();
      a = addr; m_io = mem; s0_w_l = !wrc; s1_r_l = wrc; cd_setup_l = !setup;
      adl_l = 1'b0; cms_dtack_l = 1'b1;
      tb_d = wd; tb_d_en = wrc;
      tick();
      adl_l = 1'b1; cmd = 1'b0;
   endtask

   task automatic end_cycle();
      tick();
      cmd = 1'b1; tb_d_en = 1'b0; cd_setup_l = 1'b1;
   endtask

   task automatic pos_wr(input logic [15:0] addr, input logic [7:0] v);
      start_cycle(1'b1, 1'b0, 1'b1, addr, v);
      end_cycle();
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      chreset_l = 0; cd_setup_l = 1; adl_l = 1; cmd = 1; m_io = 0; s0_w_l = 1; s1_r_l = 1;
      a = 16'h0; cms_dtack_l = 1; irq_in = 0; dreq = 0; tc_l = 1; arb_grant_l = 1;
      tb_d = 8'h00; tb_d_en = 0; arb_force = 0;
      repeat (3) tick();
      exp(F_CS, 8'hFF, "rst_cs");    exp(F_STB, 8'h0E, "rst_stb");
      exp(F_SFB, 8'h00, "rst_sfdbk"); exp(F_CHRDY, 8'h00, "rst_chrdy");
      exp(F_IRQ, 8'h00, "rst_irq");  exp(F_DACK, 8'h01, "rst_dack");
      exp(F_PRE, 8'h01, "rst_preempt"); exp(F_ARB, 8'h0F, "rst_arb");
      exp(F_BURST, 8'h01, "rst_burst"); exp(F_D, 8'hFF, "rst_d_hiz");
      tick();
      chreset_l = 1;

      // POS reads of the adapter ID
      start_cycle(1, 0, 0, 16'h0000, 8'h00);
      exp(F_D, 8'h03, "pos0_rd"); exp(F_SFB, 8'h01, "pos0_sfdbk"); exp(F_STB, 8'h0D, "pos0_stb");
      end_cycle();
      start_cycle(1, 0, 0, 16'h0001, 8'h00);
      exp(F_D, 8'h51, "pos1_rd");
      end_cycle();

      // configure: base 0x220, arb level 11, IRQ2, enabled
      pos_wr(16'h0003, 8'hB2);
      pos_wr(16'h0002, 8'h01);
      start_cycle(1, 0, 0, 16'h0003, 8'h00); exp(F_D, 8'hB2, "pos3_rd"); end_cycle();
      start_cycle(1, 0, 0, 16'h0002, 8'h00); exp(F_D, 8'h01, "pos2_rd"); end_cycle();
      start_cycle(1, 0, 0, 16'h0005, 8'h00); exp(F_D, 8'h00, "pos5_rd"); end_cycle();

      // I/O decode
      start_cycle(0, 0, 1, 16'h0388, 8'hCC);
      exp(F_CS, 8'h7F, "ym388_cs"); exp(F_STB, 8'h08, "ym388_stb");
      exp(F_A0, 8'h00, "ym388_a0"); exp(F_SFB, 8'h01, "ym388_sfdbk");
      end_cycle();

      start_cycle(0, 0, 1, 16'h0220, 8'h22);
      exp(F_CS, 8'hDF, "cms220_cs"); exp(F_CHRDY, 8'h01, "cms_chrdy_wait");
      repeat (4) tick();
      exp(F_CHRDY, 8'h01, "cms_chrdy_hold");
      tick();
      cms_dtack_l = 0;
      exp(F_CHRDY, 8'h00, "cms_chrdy_dtack");
      end_cycle();

      start_cycle(0, 0, 1, 16'h0226, 8'h00);
      exp(F_CS, 8'hF7, "rst226_cs"); exp(F_CHRDY, 8'h00, "rst226_chrdy");
      end_cycle();
      start_cycle(0, 0, 0, 16'h022E, 8'h00);
      exp(F_CS, 8'hFB, "dav22e_cs"); exp(F_STB, 8'h05, "dav22e_stb");
      end_cycle();
      start_cycle(0, 0, 0, 16'h022A, 8'h00); exp(F_CS, 8'hFE, "drd22a_cs"); end_cycle();
      start_cycle(0, 0, 0, 16'h022C, 8'h00); exp(F_CS, 8'hFD, "dwr22c_rd_cs"); end_cycle();
      start_cycle(0, 0, 1, 16'h022A, 8'h00); exp(F_CS, 8'hFF, "drd22a_wr_cs"); end_cycle();
      start_cycle(0, 0, 1, 16'h0223, 8'h00);
      exp(F_CS, 8'hEF, "cms223_cs"); exp(F_A0, 8'h01, "cms223_a0");
      end_cycle();
      start_cycle(0, 0, 0, 16'h0389, 8'h00);
      exp(F_CS, 8'h7F, "ym389_cs"); exp(F_A0, 8'h01, "ym389_a0");
      end_cycle();
      start_cycle(0, 0, 0, 16'h0203, 8'h00); exp(F_CS, 8'hBF, "joy203_cs"); end_cycle();
      start_cycle(0, 0, 0, 16'h0234, 8'h00);
      exp(F_CS, 8'hFF, "miss234_cs"); exp(F_STB, 8'h0F, "miss234_stb"); exp(F_SFB, 8'h00, "miss234_sfdbk");
      end_cycle();
      start_cycle(0, 1, 1, 16'h0388, 8'h00); exp(F_CS, 8'hFF, "mem388_cs"); end_cycle();

      // IRQ routing
      tick(); irq_in = 1; exp(F_IRQ, 8'h08, "irq2_hi");
      repeat (3) tick(); exp(F_IRQ, 8'h08, "irq2_hold");
      tick(); irq_in = 0; exp(F_IRQ, 8'h00, "irq2_lo");
      pos_wr(16'h0002, 8'h05);
      tick(); irq_in = 1; exp(F_IRQ, 8'h02, "irq5_hi");
      tick(); irq_in = 0;
      pos_wr(16'h0002, 8'h01);

      // DMA arbitration, uncontested
      tick(); dreq = 1;
      repeat (4) tick();
      exp(F_PRE, 8'h00, "req_preempt"); exp(F_DACK, 8'h01, "req_dack");
      repeat (2) tick(); exp(F_ARB, 8'h0B, "arb_level");
      tick(); arb_grant_l = 0;
      repeat (5) tick();
      exp(F_DACK, 8'h00, "grant_dack"); exp(F_PRE, 8'h01, "grant_preempt"); exp(F_ARB, 8'h0F, "grant_arb");
      tick(); arb_grant_l = 1;
      repeat (5) tick();
      exp(F_DACK, 8'h01, "rearb_dack"); exp(F_PRE, 8'h00, "rearb_preempt");
      // contested: bus forced to 0000
      repeat (2) tick(); arb_force = 1;
      repeat (3) tick(); arb_grant_l = 0;
      repeat (5) tick();
      exp(F_DACK, 8'h01, "lost_dack"); exp(F_PRE, 8'h00, "lost_preempt");
      // retry uncontested, then terminal count ends the grant
      tick(); arb_force = 0; arb_grant_l = 1;
      repeat (6) tick(); arb_grant_l = 0;
      repeat (5) tick(); exp(F_DACK, 8'h00, "retry_dack");
      tick(); dreq = 0;
      repeat (3) tick(); tc_l = 0;
      repeat (2) tick();
      exp(F_DACK, 8'h01, "tc_dack"); exp(F_PRE, 8'h01, "tc_preempt");
      tick(); tc_l = 1;
      // reset in the middle of a grant
      tick(); dreq = 1; arb_grant_l = 1;
      repeat (6) tick(); arb_grant_l = 0;
      repeat (5) tick(); exp(F_DACK, 8'h00, "pre_rst_dack");
      tick(); chreset_l = 0;
      tick();
      exp(F_DACK, 8'h01, "midrst_dack"); exp(F_ARB, 8'h0F, "midrst_arb");
      exp(F_PRE, 8'h01, "midrst_preempt"); exp(F_IRQ, 8'h00, "midrst_irq");
      repeat (2) tick();

      n_chk++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
